// File: rtl/fir_coeff_loader.sv
// Coefficient reload controller for a double-banked FIR: streams a full tap set
// into the shadow bank, then swaps banks on the next FIR sample strobe.
module fir_coeff_loader #(
    parameter int N_TAPS      = 71,
    parameter int COEFF_WIDTH = 20,
    parameter int ADDR_WIDTH  = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_start,
    input  logic                   cfg_abort,
    input  logic [COEFF_WIDTH-1:0] cfg_coeff,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic                   fir_valid_in,
    output logic                   coeff_wr_en,
    output logic [ADDR_WIDTH-1:0]  coeff_wr_addr,
    output logic [COEFF_WIDTH-1:0] coeff_wr_data,
    output logic                   coeff_wr_bank,
    output logic                   bank_sel,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [1:0]             dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SWAP = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] LAST_TAP = ADDR_WIDTH'(N_TAPS - 1);

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [ADDR_WIDTH-1:0] tap_cnt;
    logic                  handshake;
    logic                  last_tap;
    logic                  accept_start;
    logic                  swap_now;
    logic                  abort_now;
    logic                  start_err;

    // Handshake: a tap is transferred on a cycle where cfg_valid and cfg_ready
    // are both high; cfg_ready depends on the state register only. An abort in
    // the same cycle cancels the transfer.
    assign cfg_ready = (state == ST_LOAD);
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    assign abort_now    = busy & cfg_abort;
    assign handshake    = cfg_valid & cfg_ready & ~cfg_abort;
    assign last_tap     = (tap_cnt == LAST_TAP);
    assign accept_start = (state == ST_IDLE) & cfg_start;
    assign swap_now     = (state == ST_SWAP) & fir_valid_in & ~cfg_abort;
    assign start_err    = busy & cfg_start & ~cfg_abort;

    // The write bank is always the one the FIR is not reading.
    assign coeff_wr_bank = ~bank_sel;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cfg_abort) begin
                    state_next = ST_IDLE;
                end else if (handshake && last_tap) begin
                    state_next = ST_SWAP;
                end
            end
            ST_SWAP: begin
                if (cfg_abort || fir_valid_in) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            tap_cnt       <= '0;
            bank_sel      <= 1'b0;
            coeff_wr_en   <= 1'b0;
            coeff_wr_addr <= '0;
            coeff_wr_data <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            state       <= state_next;
            coeff_wr_en <= handshake;
            done        <= swap_now;

            if (accept_start) begin
                tap_cnt <= '0;
            end else if (handshake) begin
                tap_cnt <= tap_cnt + 1'b1;
            end

            if (handshake) begin
                coeff_wr_addr <= tap_cnt;
                coeff_wr_data <= cfg_coeff;
            end

            if (swap_now) begin
                bank_sel <= ~bank_sel;
            end

            // Sticky: only a fresh accepted start (or reset) clears it.
            if (accept_start) begin
                error <= 1'b0;
            end else if (abort_now || start_err) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Coefficient reload controller for the FIR_Filter datapath (N_TAPS=71, 20-bit Q2.18 coefficients). It accepts a full coefficient set from a host over a valid/ready stream and writes it into the inactive (shadow) coefficient bank of a double-banked FIR. It then swaps banks exactly on a sample boundary, so every output sample is computed with one complete coefficient set. It sits between the control/register interface and the FIR coefficient storage, and observes the FIR sample strobe.

## Interface
- N_TAPS, 71, coefficients per set
- COEFF_WIDTH, 20, coefficient width (signed, passed through unchanged)
- ADDR_WIDTH, 7, coefficient address width; must satisfy 2^ADDR_WIDTH >= N_TAPS

- clk  in  1  single clock
- rst  in  1  synchronous reset, active-high
- cfg_start  in  1  request a new load sequence
- cfg_abort  in  1  cancel the load or swap in progress
- cfg_coeff  in  COEFF_WIDTH  coefficient data, tap 0 first
- cfg_valid  in  1  cfg_coeff valid
- cfg_ready  out  1  loader accepts cfg_coeff
- fir_valid_in  in  1  FIR input sample strobe (same signal that drives FIR valid_in)
- coeff_wr_en  out  1  shadow-bank write strobe
- coeff_wr_addr  out  ADDR_WIDTH  tap index being written
- coeff_wr_data  out  COEFF_WIDTH  coefficient being written
- coeff_wr_bank  out  1  bank written; always equals ~bank_sel
- bank_sel  out  1  bank the FIR currently uses
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse when the new bank becomes active
- error  out  1  sticky protocol-error flag

## Operation
- States: IDLE, LOAD, SWAP. Reset puts the FSM in IDLE.
- IDLE:
  - cfg_start=1 moves to LOAD, clears tap counter and error.
  - cfg_valid is ignored.
- LOAD:
  - cfg_ready=1.
  - A handshake (cfg_valid & cfg_ready) writes the tap: next cycle coeff_wr_en=1, coeff_wr_addr=counter, coeff_wr_data=cfg_coeff, coeff_wr_bank=~bank_sel. The counter then increments.
  - The handshake for tap N_TAPS-1 moves to SWAP.
  - Gaps in cfg_valid are allowed with no timeout.
- SWAP:
  - cfg_ready=0.
  - At the first edge with fir_valid_in=1, bank_sel toggles, done=1 for the following cycle, and the FSM returns to IDLE.
- Abort: cfg_abort=1 in LOAD or SWAP returns the FSM to IDLE with bank_sel unchanged, no further writes, and error=1.
- cfg_start in LOAD/SWAP is ignored, sets error=1, and does not restart the sequence.
- Simultaneous events:
  - abort with the final-tap handshake: abort wins, no swap. The final write is suppressed.
  - abort with fir_valid_in in SWAP: abort wins, no toggle.
  - abort with start in LOAD/SWAP: abort wins, start is ignored.
- error clears only on rst or on an accepted cfg_start in IDLE.
- Partially written shadow contents after an abort are don't-care; the next load overwrites all taps.

## Timing
- Reset values (registered, at the edge with rst=1):
  - state=IDLE, bank_sel=0, coeff_wr_en=0, coeff_wr_addr=0, coeff_wr_data=0, coeff_wr_bank=1, done=0, error=0.
  - cfg_ready=0 and busy=0 (decoded from state).
- Reset mid-operation discards the sequence and returns bank_sel to 0.
- cfg_ready and busy decode the state register only; they have no combinational path from inputs.
- Write latency: coeff_wr_* is 1 cycle after its handshake.
- Minimum load: N_TAPS cycles in LOAD, plus SWAP wait.
- Swap latency: bank_sel changes at the edge sampling fir_valid_in=1 in SWAP.
  - The sample taken at that edge and all later samples use the new bank.
  - The final coefficient write (issued that same edge or earlier) is complete before the first sample that uses the new bank.
- done is asserted in the same cycle that bank_sel first shows the new value.
- If fir_valid_in is held high continuously, the swap occurs on the first SWAP cycle.

## Test plan
- Reset, then start and stream 71 coefficients 0..70 back-to-back with fir_valid_in=1 constantly:
  - writes appear at addr 0..70 with coeff_wr_bank=1, one cycle after each handshake.
  - bank_sel goes 0→1 on the first SWAP edge, with done pulsed once. error=0.
- Same load with fir_valid_in low for 10 cycles after the last tap: FSM holds SWAP for 10 cycles, bank_sel toggles at the first fir_valid_in=1 edge, busy is high throughout.
- Throttled host (cfg_valid every 3rd cycle): exactly 71 writes with contiguous addresses. A second full load writes coeff_wr_bank=0 and returns bank_sel to 0.
- cfg_abort after 30 handshakes: the FSM returns to IDLE, bank_sel is unchanged, error=1.
  - The next cfg_start clears error, and a full load succeeds.
- cfg_abort in the same cycle as the tap-70 handshake: no write for tap 70, no swap, error=1.
  - cfg_start during LOAD: error=1 and the tap count is unaffected.
- rst=1 in SWAP: the next cycle has all outputs at their reset values, bank_sel=0, and no done pulse.
